// File: rtl/datatype_cast_pkg.sv
// Shared constants for the datatype_cast_pipe fixed-point cast unit:
// operation codes, rounding modes and immediate field positions.
package datatype_cast_pkg;

  // Operation codes carried with each beat
  localparam logic [3:0] FN_SAT16   = 4'b0000;
  localparam logic [3:0] FN_SAT8    = 4'b0001;
  localparam logic [3:0] FN_SAT4    = 4'b0010;
  localparam logic [3:0] FN_WIDEN16 = 4'b0011;
  localparam logic [3:0] FN_WIDEN8  = 4'b0100;
  localparam logic [3:0] FN_WIDEN4  = 4'b0101;
  localparam logic [3:0] FN_FLOOR   = 4'b1000;
  localparam logic [3:0] FN_CEIL    = 4'b1001;

  // Rounding modes applied on a right shift
  localparam logic [1:0] RND_TRUNC       = 2'b00;
  localparam logic [1:0] RND_HALF_UP     = 2'b01;
  localparam logic [1:0] RND_HALF_EVEN   = 2'b10;
  localparam logic [1:0] RND_TOWARD_ZERO = 2'b11;

  // Immediate word layout: fi at [5:0], fo at [21:16], mode at [31:30]
  localparam int IMM_FI_LSB  = 0;
  localparam int IMM_FO_LSB  = 16;
  localparam int IMM_FRAC_W  = 6;
  localparam int IMM_RND_LSB = 30;
  localparam int IMM_RND_W   = 2;

endpackage

// File: rtl/datatype_cast_pipe_cast_lane.sv
// One lane of the cast pipeline: S1 rescales (shift + round) or applies
// floor/ceil, S2 saturates to the selected width and sign-extends.
module cast_lane
  import datatype_cast_pkg::*;
#(
  parameter int IN_WIDTH      = 32,
  parameter int OUT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_ld_p1,
  input  logic                         i_ld_p2,
  input  logic [FUNCTION_BITS-1:0]     i_fn,
  input  logic [FUNCTION_BITS-1:0]     i_fn_p1,
  input  logic [IMM_FRAC_W-1:0]        i_fi,
  input  logic [IMM_FRAC_W-1:0]        i_fo,
  input  logic [IMM_RND_W-1:0]         i_rnd,
  input  logic signed [IN_WIDTH-1:0]   i_data,
  output logic signed [OUT_WIDTH-1:0]  o_data,
  output logic                         o_sat
);

  // VW: intermediate width; WW: wide enough for a 63-bit left shift; SW: clamp compare width
  localparam int VW = IN_WIDTH + 1;
  localparam int WW = IN_WIDTH + 66;
  localparam int SW = IN_WIDTH + OUT_WIDTH + 2;

  // Arithmetic right shift by d with the selected rounding; d>=IN_WIDTH collapses to sign fill or 0
  function automatic logic signed [VW-1:0] f_round_shr(
    input logic signed [IN_WIDTH-1:0] x,
    input logic [IMM_FRAC_W-1:0]      d,
    input logic [IMM_RND_W-1:0]       mode
  );
    logic signed [VW-1:0] xe;
    logic signed [VW-1:0] q;
    logic signed [VW-1:0] res;
    logic [VW-1:0]        mask;
    logic [VW-1:0]        rem;
    logic [VW-1:0]        half;
    logic                 inc;
    xe   = {x[IN_WIDTH-1], x};
    q    = xe >>> d;
    mask = ~({VW{1'b1}} << d);
    rem  = xe & mask;
    half = {{(VW-1){1'b0}}, 1'b1} << (d - 6'd1);
    inc  = 1'b0;
    res  = q;
    if (d == '0) begin
      res = xe;
    end else if (int'(d) >= IN_WIDTH) begin
      res = (mode == RND_TRUNC && x[IN_WIDTH-1]) ? {VW{1'b1}} : {VW{1'b0}};
    end else begin
      case (mode)
        RND_TRUNC:     inc = 1'b0;
        RND_HALF_UP:   inc = (rem >= half);
        RND_HALF_EVEN: inc = (rem > half) || ((rem == half) && q[0]);
        default:       inc = x[IN_WIDTH-1] && (rem != '0);
      endcase
      res = q + VW'(inc);
    end
    return res;
  endfunction

  // Clamp to a w-bit signed range (forced by ovf), returns {flag, value}
  function automatic logic [OUT_WIDTH:0] f_sat(
    input logic signed [VW-1:0] v,
    input logic                 ovf,
    input logic                 neg,
    input int                   w,
    input logic                 clamp
  );
    logic signed [SW-1:0]  ve;
    logic signed [SW-1:0]  maxv;
    logic signed [SW-1:0]  minv;
    logic [OUT_WIDTH-1:0]  res;
    logic                  flag;
    ve   = {{(SW-VW){v[VW-1]}}, v};
    maxv = ({{(SW-1){1'b0}}, 1'b1} << (w - 1)) - 1;
    minv = ~maxv;
    flag = 1'b0;
    res  = ve[OUT_WIDTH-1:0];
    if (ovf) begin
      flag = 1'b1;
      res  = neg ? minv[OUT_WIDTH-1:0] : maxv[OUT_WIDTH-1:0];
    end else if (clamp && (ve > maxv)) begin
      flag = 1'b1;
      res  = maxv[OUT_WIDTH-1:0];
    end else if (clamp && (ve < minv)) begin
      flag = 1'b1;
      res  = minv[OUT_WIDTH-1:0];
    end
    return {flag, res};
  endfunction

  logic [WW-1:0]         w_xw;
  logic [WW-1:0]         w_shl;
  logic [WW-1:0]         w_mask;
  logic [WW-1:0]         w_ceil;
  logic [VW-1:0]         w_floor;
  logic                  w_shl_ovf;
  logic                  w_ceil_ovf;
  logic signed [VW-1:0]  w_val;
  logic                  w_ovf;
  logic                  w_neg;
  logic [OUT_WIDTH:0]    w_res;

  logic signed [VW-1:0]  r_val_p1;
  logic                  r_ovf_p1;
  logic                  r_neg_p1;
  logic signed [OUT_WIDTH-1:0] r_data_p2;
  logic                  r_sat_p2;

  assign w_xw       = {{(WW-IN_WIDTH){i_data[IN_WIDTH-1]}}, i_data};
  assign w_shl      = w_xw << (i_fo - i_fi);
  assign w_shl_ovf  = w_shl != {{(WW-IN_WIDTH){w_shl[IN_WIDTH-1]}}, w_shl[IN_WIDTH-1:0]};
  assign w_mask     = ~({WW{1'b1}} << i_fi);
  assign w_floor    = w_xw[VW-1:0] & ~w_mask[VW-1:0];
  assign w_ceil     = (w_xw + w_mask) & ~w_mask;
  assign w_ceil_ovf = w_ceil != {{(WW-IN_WIDTH){w_ceil[IN_WIDTH-1]}}, w_ceil[IN_WIDTH-1:0]};

  // S1 select: floor/ceil on raw data, otherwise rescale by fi-fo; ovf direction from input sign
  always_comb begin
    w_val = {i_data[IN_WIDTH-1], i_data};
    w_ovf = 1'b0;
    w_neg = i_data[IN_WIDTH-1];
    if (i_fn == FUNCTION_BITS'(FN_FLOOR)) begin
      w_val = w_floor;
    end else if (i_fn == FUNCTION_BITS'(FN_CEIL)) begin
      w_val = w_ceil[VW-1:0];
      w_ovf = w_ceil_ovf;
      w_neg = 1'b0;
    end else if (i_fi > i_fo) begin
      w_val = f_round_shr(i_data, i_fi - i_fo, i_rnd);
    end else if (i_fi < i_fo) begin
      w_val = w_shl[VW-1:0];
      w_ovf = w_shl_ovf;
    end
  end

  // ---- S1 boundary: scaled intermediate plus overflow direction ----
  always_ff @(posedge clk) begin
    if (i_ld_p1) begin
      r_val_p1 <= w_val;
      r_ovf_p1 <= w_ovf;
      r_neg_p1 <= w_neg;
    end
  end

  // S2 decode: narrow saturation, widen/floor/ceil clamp only on overflow, else zero
  always_comb begin
    w_res = '0;
    case (i_fn_p1)
      FUNCTION_BITS'(FN_SAT16): w_res = f_sat(r_val_p1, r_ovf_p1, r_neg_p1, 16, 1'b1);
      FUNCTION_BITS'(FN_SAT8):  w_res = f_sat(r_val_p1, r_ovf_p1, r_neg_p1, 8, 1'b1);
      FUNCTION_BITS'(FN_SAT4):  w_res = f_sat(r_val_p1, r_ovf_p1, r_neg_p1, 4, 1'b1);
      FUNCTION_BITS'(FN_WIDEN16),
      FUNCTION_BITS'(FN_WIDEN8),
      FUNCTION_BITS'(FN_WIDEN4),
      FUNCTION_BITS'(FN_FLOOR),
      FUNCTION_BITS'(FN_CEIL):  w_res = f_sat(r_val_p1, r_ovf_p1, r_neg_p1, OUT_WIDTH, 1'b0);
      default:                  w_res = '0;
    endcase
  end

  // ---- S2 boundary: final lane result and saturation flag ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_p2 <= '0;
      r_sat_p2  <= 1'b0;
    end else if (i_ld_p2) begin
      r_data_p2 <= w_res[OUT_WIDTH-1:0];
      r_sat_p2  <= w_res[OUT_WIDTH];
    end
  end

  assign o_data = r_data_p2;
  assign o_sat  = r_sat_p2;

endmodule

// File: rtl/datatype_cast_pipe.sv
// Multi-lane 2-stage fixed-point cast unit with valid/ready flow control.
// Optional macro DATATYPE_CAST_SAT_COUNT_EN builds the saturated-lane counter
// on sat_count; without it sat_count is constant zero.
module datatype_cast_pipe
  import datatype_cast_pkg::*;
#(
  parameter int LANES         = 4,
  parameter int IN_WIDTH      = 32,
  parameter int OUT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [FUNCTION_BITS-1:0]     fn,
  input  logic [31:0]                  immediate,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*IN_WIDTH-1:0]    data_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*OUT_WIDTH-1:0]   data_out,
  output logic [LANES-1:0]             sat_flag,
  output logic [31:0]                  sat_count
);

  logic                     r_vld_p1;
  logic                     r_vld_p2;
  logic [FUNCTION_BITS-1:0] r_fn_p1;
  logic                     w_s2_adv;
  logic                     w_accept;
  logic                     w_ld_p2;
  logic [IMM_FRAC_W-1:0]    w_fi;
  logic [IMM_FRAC_W-1:0]    w_fo;
  logic [IMM_RND_W-1:0]     w_rnd;
  logic                     w_unused_imm;

  assign w_fi  = immediate[IMM_FI_LSB +: IMM_FRAC_W];
  assign w_fo  = immediate[IMM_FO_LSB +: IMM_FRAC_W];
  assign w_rnd = immediate[IMM_RND_LSB +: IMM_RND_W];
  assign w_unused_imm = ^{immediate[IMM_FO_LSB-1:IMM_FI_LSB+IMM_FRAC_W],
                          immediate[IMM_RND_LSB-1:IMM_FO_LSB+IMM_FRAC_W]};

  // S2 moves whenever the output slot is empty or being taken; S1 frees behind it
  assign w_s2_adv  = !r_vld_p2 || out_ready;
  assign in_ready  = !r_vld_p1 || w_s2_adv;
  assign w_accept  = in_valid && in_ready;
  assign w_ld_p2   = w_s2_adv && r_vld_p1;
  assign out_valid = r_vld_p2;

  // Stage valids: S1 refills or empties when ready, S2 follows S1 when advancing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (in_ready) r_vld_p1 <= in_valid;
      if (w_s2_adv) r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- S1 boundary: operation code travels with the beat ----
  always_ff @(posedge clk) begin
    if (w_accept) r_fn_p1 <= fn;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cast_lane #(
      .IN_WIDTH      (IN_WIDTH),
      .OUT_WIDTH     (OUT_WIDTH),
      .FUNCTION_BITS (FUNCTION_BITS)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_ld_p1 (w_accept),
      .i_ld_p2 (w_ld_p2),
      .i_fn    (fn),
      .i_fn_p1 (r_fn_p1),
      .i_fi    (w_fi),
      .i_fo    (w_fo),
      .i_rnd   (w_rnd),
      .i_data  (data_in[g*IN_WIDTH +: IN_WIDTH]),
      .o_data  (data_out[g*OUT_WIDTH +: OUT_WIDTH]),
      .o_sat   (sat_flag[g])
    );
  end

`ifdef DATATYPE_CAST_SAT_COUNT_EN
  function automatic logic [31:0] f_popcount(input logic [LANES-1:0] v);
    logic [31:0] n;
    n = '0;
    for (int k = 0; k < LANES; k++) n = n + 32'(v[k]);
    return n;
  endfunction

  logic [31:0] r_sat_count;
  logic [32:0] w_cnt_sum;

  assign w_cnt_sum = {1'b0, r_sat_count} + {1'b0, f_popcount(sat_flag)};

  // Accumulate clamped lanes per output handshake, sticking at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_count <= '0;
    end else if (out_valid && out_ready) begin
      r_sat_count <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
    end
  end

  assign sat_count = r_sat_count;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_datatype_cast_pipe.sv
// Directed self-checking bench for datatype_cast_pipe (4 lanes x 32 bits).
module tb_datatype_cast_pipe;

  logic         clk;
  logic         reset;
  logic [3:0]   fn;
  logic [31:0]  immediate;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [3:0]   sat_flag;
  logic [31:0]  sat_count;

  int n_checks = 0;
  int n_errors = 0;
  int sent;
  int recv;

`ifdef DATATYPE_CAST_SAT_COUNT_EN
  localparam logic [31:0] CNT_AFTER3 = 32'd6;
`else
  localparam logic [31:0] CNT_AFTER3 = 32'd0;
`endif

  datatype_cast_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .fn        (fn),
    .immediate (immediate),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input logic [31:0] l0, input logic [31:0] l1,
                                         input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] imm(input logic [5:0] fi, input logic [5:0] fo,
                                      input logic [1:0] m);
    return {m, 8'd0, fo, 10'd0, fi};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one beat for one cycle, confirm it appears exactly two edges later
  task automatic send_one(input logic [3:0] f, input logic [31:0] im, input logic [127:0] d);
    fn = f; immediate = im; data_in = d; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("latency_not_early", out_valid, 1'b0);
    @(negedge clk);
    chk("latency_valid", out_valid, 1'b1);
  endtask

  initial begin
    reset = 1'b1; fn = '0; immediate = '0; in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, '0);
    chk("rst_sat_flag", sat_flag, '0);
    chk("rst_sat_count", sat_count, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    // 0x18080 at Q16 -> Q8 with half-up: 385
    send_one(4'b0000, imm(6'd16, 6'd8, 2'b01), pack4(32'h0001_8080, 0, 0, 0));
    chk("halfup_data", data_out, pack4(32'h0000_0181, 0, 0, 0));
    chk("halfup_flag", sat_flag, 4'b0000);

    send_one(4'b0001, imm(6'd0, 6'd0, 2'b00), pack4(32'd300, -32'sd300, 32'd127, -32'sd128));
    chk("sat8_data", data_out, pack4(32'h0000_007F, 32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_FF80));
    chk("sat8_flag", sat_flag, 4'b0011);

    send_one(4'b0000, imm(6'd1, 6'd0, 2'b10), pack4(32'd5, 32'd7, -32'sd5, -32'sd3));
    chk("half_even_data", data_out, pack4(32'd2, 32'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFE));
    chk("half_even_flag", sat_flag, 4'b0000);

    send_one(4'b1001, imm(6'd4, 6'd0, 2'b00), pack4(-32'sd24, 32'h7FFF_FFF1, 32'h25, 32'h20));
    chk("ceil_data", data_out, pack4(32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'h30, 32'h20));
    chk("ceil_flag", sat_flag, 4'b0010);

    send_one(4'b1000, imm(6'd4, 6'd0, 2'b00), pack4(-32'sd24, 32'h7FFF_FFF1, 32'h25, 32'h20));
    chk("floor_data", data_out, pack4(32'hFFFF_FFE0, 32'h7FFF_FFF0, 32'h20, 32'h20));
    chk("floor_flag", sat_flag, 4'b0000);

    send_one(4'b0011, imm(6'd0, 6'd4, 2'b00), pack4(32'h1000_0000, 32'hF000_0000, 32'h07FF_FFFF, 32'hFFFF_FFFF));
    chk("widen_ovf_data", data_out, pack4(32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFF0, 32'hFFFF_FFF0));
    chk("widen_ovf_flag", sat_flag, 4'b0011);

    send_one(4'b0010, imm(6'd2, 6'd0, 2'b11), pack4(-32'sd7, 32'd7, 32'd40, -32'sd40));
    chk("sat4_tz_data", data_out, pack4(32'hFFFF_FFFF, 32'd1, 32'd7, 32'hFFFF_FFF8));
    chk("sat4_tz_flag", sat_flag, 4'b1100);

    send_one(4'b0011, imm(6'd40, 6'd0, 2'b00), pack4(-32'sd5, 32'd5, 32'h7FFF_FFFF, 32'h8000_0000));
    chk("big_shift_trunc", data_out, pack4(32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF));

    send_one(4'b0011, imm(6'd40, 6'd0, 2'b01), pack4(-32'sd5, 32'd5, 32'h7FFF_FFFF, 32'h8000_0000));
    chk("big_shift_round", data_out, '0);

    send_one(4'b1000, imm(6'd0, 6'd0, 2'b00), pack4(-32'sd24, 32'h1234_5678, 32'h8000_0000, 32'd7));
    chk("floor_fi0_identity", data_out, pack4(-32'sd24, 32'h1234_5678, 32'h8000_0000, 32'd7));

    send_one(4'b0111, imm(6'd0, 6'd0, 2'b00), pack4(32'd9, 32'd300, -32'sd1, 32'd5));
    chk("undef_fn_data", data_out, '0);
    chk("undef_fn_flag", sat_flag, 4'b0000);

    @(negedge clk);
    chk("drained", out_valid, 1'b0);

    // Streaming with a 5-cycle output stall: order, stability and in_ready
    fn = 4'b0011; immediate = '0; sent = 0; recv = 0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid  = (sent < 8);
      data_in   = pack4(32'h100 + 32'(sent), 0, 0, 0);
      #1;
      chk("bp_in_ready", in_ready, ((sent - recv) < 2) || out_ready);
      if (out_valid) begin
        chk("bp_data_order", data_out, pack4(32'h100 + 32'(recv), 0, 0, 0));
        if (out_ready) recv++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    chk("bp_all_received", 32'(recv), 32'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);

    // Reset mid-flight after three saturating beats (two clamped lanes each)
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int b = 0; b < 3; b++)
      send_one(4'b0001, imm(6'd0, 6'd0, 2'b00), pack4(32'd300, -32'sd300, 32'd0, 32'd0));
    fn = 4'b0001; data_in = pack4(32'd300, -32'sd300, 32'd0, 32'd0); in_valid = 1'b1;
    @(negedge clk);
    chk("cnt_after3", sat_count, CNT_AFTER3);
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_sat_count", sat_count, '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_sat_flag", sat_flag, '0);
    reset = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_dropped", out_valid, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
